// File: rtl/tdc_thermo_decoder_pkg.sv
// Shared TDC channel defaults and elaboration helpers for the thermometer decoder.
package tdc_thermo_decoder_pkg;

    localparam int unsigned DEF_NUM_TAPS      = 240;
    localparam int unsigned DEF_HALF_NUM_TAPS = DEF_NUM_TAPS / 2;
    localparam int unsigned DEF_WRAP_OFFSET   = 240;
    localparam int unsigned DEF_BITS_DECO     = 8;
    localparam int unsigned DEF_STRIDE        = 2;
    localparam int unsigned DEF_ERR_W         = 16;
    localparam int unsigned DEF_CHUNK         = 16;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tdc_thermo_decoder_if.sv
// Sample-in / bin-out bundle between the capture flops and the fine/coarse combiner.
interface tdc_thermo_decoder_if
    import tdc_thermo_decoder_pkg::*;
#(
    parameter int unsigned NUM_TAPS  = DEF_NUM_TAPS,
    parameter int unsigned BITS_DECO = DEF_BITS_DECO,
    parameter int unsigned ERR_W     = DEF_ERR_W
);

    logic                 sample_valid;
    logic [NUM_TAPS-1:0]  sample;
    logic                 bin_valid;
    logic [BITS_DECO-1:0] bin;
    logic                 edge_right;
    logic                 no_edge;
    logic [ERR_W-1:0]     err_count;

    modport master (
        output sample_valid, sample,
        input  bin_valid, bin, edge_right, no_edge, err_count
    );

    modport slave (
        input  sample_valid, sample,
        output bin_valid, bin, edge_right, no_edge, err_count
    );

endinterface

// File: rtl/tdc_popcount_chunk.sv
// Combinational popcount of one CHUNK-wide slice of the delay-line sample.
module tdc_popcount_chunk #(
    parameter int unsigned CHUNK = 16,
    parameter int unsigned CNT_W = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] bits,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            count = count + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/tdc_thermo_decoder.sv
// Three-stage thermometer-to-bin decoder: capture, partial/side counts, fold and flag.
module tdc_thermo_decoder
    import tdc_thermo_decoder_pkg::*;
#(
    parameter int unsigned NUM_TAPS    = DEF_NUM_TAPS,
    parameter int unsigned BITS_DECO   = DEF_BITS_DECO,
    parameter int unsigned STRIDE      = DEF_STRIDE,
    parameter int unsigned WRAP_OFFSET = DEF_WRAP_OFFSET,
    parameter int unsigned ERR_W       = DEF_ERR_W,
    parameter int unsigned CHUNK       = DEF_CHUNK
) (
    input logic                  clk,
    input logic                  rst,
    tdc_thermo_decoder_if.slave  bus
);

    localparam int unsigned HALF       = NUM_TAPS / 2;
    localparam int unsigned NUM_CHUNKS = ceil_div(NUM_TAPS, CHUNK);
    localparam int unsigned PAD_W      = NUM_CHUNKS * CHUNK;
    localparam int unsigned CNT_W      = cnt_width(CHUNK);

    // S1: capture
    logic                s1_valid_q;
    logic [NUM_TAPS-1:0] s1_sample_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= bus.sample_valid;
        end
        if (bus.sample_valid) begin
            s1_sample_q <= bus.sample;
        end
    end

    // S2: partial popcounts plus strided left/right side counts
    logic [PAD_W-1:0]     padded;
    logic [CNT_W-1:0]     part_d [NUM_CHUNKS];
    logic [CNT_W-1:0]     part_q [NUM_CHUNKS];
    logic [BITS_DECO-1:0] left_d, right_d;
    logic [BITS_DECO-1:0] left_q, right_q;
    logic                 s2_valid_q;

    always_comb begin
        padded                 = '0;
        padded[NUM_TAPS-1:0]   = s1_sample_q;
    end

    for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_chunk
        tdc_popcount_chunk #(
            .CHUNK (CHUNK),
            .CNT_W (CNT_W)
        ) u_chunk (
            .bits  (padded[k*CHUNK +: CHUNK]),
            .count (part_d[k])
        );
    end

    always_comb begin
        left_d  = '0;
        right_d = '0;
        for (int unsigned j = 0; j < NUM_TAPS; j += STRIDE) begin
            if (j < HALF) begin
                left_d = left_d + BITS_DECO'(s1_sample_q[j]);
            end else begin
                right_d = right_d + BITS_DECO'(s1_sample_q[j]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
        end
        if (s1_valid_q) begin
            part_q  <= part_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    // S3: sum partials, pick the edge side, fold right-side edges
    logic [BITS_DECO-1:0] ones;
    logic                 right_side;
    logic                 no_edge_d;
    logic                 edge_right_d;
    logic [BITS_DECO-1:0] bin_d;

    always_comb begin
        ones = '0;
        for (int unsigned k = 0; k < NUM_CHUNKS; k++) begin
            ones = ones + BITS_DECO'(part_q[k]);
        end
        right_side   = (right_q >= left_q);
        no_edge_d    = (ones == '0) || (ones == BITS_DECO'(NUM_TAPS));
        bin_d        = ones;
        edge_right_d = right_side;
        if (no_edge_d) begin
            bin_d        = '0;
            edge_right_d = 1'b0;
        end else if (right_side && (ones <= BITS_DECO'(HALF))) begin
            // WRAP_OFFSET >= HALF keeps this from underflowing.
            bin_d        = BITS_DECO'(WRAP_OFFSET) - ones;
            edge_right_d = 1'b1;
        end
    end

    logic                 bin_valid_q;
    logic [BITS_DECO-1:0] bin_q;
    logic                 edge_right_q;
    logic                 no_edge_q;
    logic [ERR_W-1:0]     err_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_valid_q  <= 1'b0;
            bin_q        <= '0;
            edge_right_q <= 1'b0;
            no_edge_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            bin_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                bin_q        <= bin_d;
                edge_right_q <= edge_right_d;
                no_edge_q    <= no_edge_d;
                if (no_edge_d && !(&err_count_q)) begin
                    err_count_q <= err_count_q + ERR_W'(1);
                end
            end
        end
    end

    assign bus.bin_valid  = bin_valid_q;
    assign bus.bin        = bin_q;
    assign bus.edge_right = edge_right_q;
    assign bus.no_edge    = no_edge_q;
    assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_tdc_thermo_decoder.sv
// Directed and randomized bench for tdc_thermo_decoder against a behavioural decode model.
module tb_tdc_thermo_decoder;

    localparam int N   = 240;
    localparam int BD  = 8;
    localparam int EW  = 16;
    localparam int EW2 = 3;

    typedef struct {
        bit           v;
        logic [N-1:0] s;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdc_thermo_decoder_if #(.NUM_TAPS(N), .BITS_DECO(BD), .ERR_W(EW))  bus ();
    tdc_thermo_decoder_if #(.NUM_TAPS(N), .BITS_DECO(BD), .ERR_W(EW2)) bus2 ();

    assign bus2.sample_valid = bus.sample_valid;
    assign bus2.sample       = bus.sample;

    tdc_thermo_decoder #(
        .NUM_TAPS(N), .BITS_DECO(BD), .STRIDE(2), .WRAP_OFFSET(240), .ERR_W(EW), .CHUNK(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow counter and ragged chunking to reach saturation and the padded last chunk.
    tdc_thermo_decoder #(
        .NUM_TAPS(N), .BITS_DECO(BD), .STRIDE(2), .WRAP_OFFSET(240), .ERR_W(EW2), .CHUNK(7)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int   total = 0;
    int   bad   = 0;
    ent_t pipe[$];
    int   m_bin, m_err, m_err2;
    bit   m_er, m_ne;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Decode straight from the rules: total ones, strided half counts, fold.
    function automatic void ref_decode(input logic [N-1:0] s, output int b, output bit er,
                                       output bit ne);
        int ones, lc, rc;
        ones = $countones(s);
        lc   = 0;
        rc   = 0;
        for (int j = 0; j < N; j++) begin
            if (j % 2 == 0) begin
                if (j < N / 2) lc += int'(s[j]);
                else           rc += int'(s[j]);
            end
        end
        if (ones == 0 || ones == N) begin
            ne = 1; b = 0; er = 0;
        end else if (rc >= lc && ones <= N / 2) begin
            ne = 0; b = 240 - ones; er = 1;
        end else begin
            ne = 0; b = ones; er = (rc >= lc);
        end
    endfunction

    function automatic logic [N-1:0] thermo(input int lo, input int hi);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (i >= lo && i <= hi);
        return v;
    endfunction

    task automatic step(input bit v, input logic [N-1:0] s, input bit r);
        ent_t e;
        int   b;
        bit   er, ne;
        bus.sample_valid = v;
        bus.sample       = s;
        rst              = r;
        e.v = v && !r;
        e.s = s;
        pipe.push_back(e);
        if (r) begin
            for (int i = 0; i < pipe.size(); i++) pipe[i].v = 1'b0;
        end
        @(posedge clk);
        #1;
        e = pipe.pop_front();
        if (r) begin
            m_bin = 0; m_er = 0; m_ne = 0; m_err = 0; m_err2 = 0;
        end
        if (e.v) begin
            ref_decode(e.s, b, er, ne);
            m_bin = b; m_er = er; m_ne = ne;
            if (ne && m_err  < (1 << EW)  - 1) m_err++;
            if (ne && m_err2 < (1 << EW2) - 1) m_err2++;
        end
        chk("bin_valid",  bus.bin_valid,   e.v);
        chk("bin",        bus.bin,         m_bin);
        chk("edge_right", bus.edge_right,  m_er);
        chk("no_edge",    bus.no_edge,     m_ne);
        chk("err_count",  bus.err_count,   m_err);
        chk("bin_valid2", bus2.bin_valid,  e.v);
        chk("bin2",       bus2.bin,        m_bin);
        chk("err_count2", bus2.err_count,  m_err2);
    endtask

    logic [N-1:0] s, zeros, ones_v, bub;
    int           kind, p;

    initial begin
        zeros  = '0;
        ones_v = '1;
        rst    = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        pipe.push_back('{v: 1'b0, s: zeros});
        pipe.push_back('{v: 1'b0, s: zeros});
        step(0, zeros, 1);
        step(0, zeros, 1);
        chk("rst_bin_valid", bus.bin_valid, 0);
        chk("rst_err",       bus.err_count, 0);

        // Left edge
        step(1, thermo(0, 99), 0);
        step(0, zeros, 0);
        step(0, zeros, 0);
        chk("left_valid", bus.bin_valid, 1);
        chk("left_bin",   bus.bin, 100);
        chk("left_er",    bus.edge_right, 0);
        chk("left_ne",    bus.no_edge, 0);
        step(0, zeros, 0);
        chk("hold_bin",   bus.bin, 100);

        // Right edge
        step(1, thermo(180, 239), 0);
        step(0, zeros, 0);
        step(0, zeros, 0);
        chk("right_bin", bus.bin, 180);
        chk("right_er",  bus.edge_right, 1);

        // Bubble
        bub     = thermo(0, 99);
        bub[50] = 1'b0;
        step(1, bub, 0);
        step(0, zeros, 0);
        step(0, zeros, 0);
        chk("bubble_bin", bus.bin, 99);
        chk("bubble_ne",  bus.no_edge, 0);
        chk("bubble_err", bus.err_count, 0);

        // No edge back-to-back
        step(1, zeros, 0);
        step(1, ones_v, 0);
        step(0, zeros, 0);
        chk("noedge0_valid", bus.bin_valid, 1);
        chk("noedge0_ne",    bus.no_edge, 1);
        chk("noedge0_bin",   bus.bin, 0);
        step(0, zeros, 0);
        chk("noedge1_valid", bus.bin_valid, 1);
        chk("noedge1_ne",    bus.no_edge, 1);
        chk("noedge_err",    bus.err_count, 2);

        // Streaming: five distinct samples on consecutive cycles
        for (int i = 0; i < 5; i++) begin
            p = $urandom_range(1, N - 1);
            step(1, (i % 2 == 0) ? thermo(0, p - 1) : thermo(p, N - 1), 0);
        end
        step(0, zeros, 0);
        step(0, zeros, 0);

        // Reset mid-flight, including a sample offered during rst
        step(1, thermo(0, 30), 0);
        step(1, zeros, 0);
        step(1, thermo(0, 60), 1);
        chk("midrst_err", bus.err_count, 0);
        for (int i = 0; i < 4; i++) step(0, zeros, 0);
        step(1, thermo(0, 99), 0);
        step(0, zeros, 0);
        step(0, zeros, 0);
        chk("postrst_valid", bus.bin_valid, 1);
        chk("postrst_bin",   bus.bin, 100);

        // Saturate the narrow error counter
        for (int i = 0; i < 10; i++) step(1, (i % 2 == 0) ? zeros : ones_v, 0);
        step(0, zeros, 0);
        step(0, zeros, 0);
        chk("sat_err2", bus2.err_count, 7);
        chk("sat_err",  bus.err_count, 10);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 300; c++) begin
            kind = $urandom_range(0, 4);
            p    = $urandom_range(1, N - 1);
            case (kind)
                0: s = thermo(0, p - 1);
                1: s = thermo(p, N - 1);
                2: s = ($urandom_range(0, 1) != 0) ? zeros : ones_v;
                3: for (int i = 0; i < N; i++) s[i] = 1'($urandom_range(0, 1));
                default: begin
                    s = thermo(0, p - 1);
                    s[$urandom_range(0, N - 1)] ^= 1'b1;
                end
            endcase
            step($urandom_range(0, 3) != 0, s, $urandom_range(0, 60) == 0);
        end
        step(0, zeros, 0);
        step(0, zeros, 0);
        step(0, zeros, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
